// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 definitions: read-engine state encoding plus register-select
// and status-bit constants, also used by the write sequencer.
package lcd1602_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_GAP
    } lcd_rd_state_t;

    localparam logic RS_INST = 1'b0;
    localparam logic RS_DATA = 1'b1;
    localparam int   BF_BIT  = 7;
    localparam int   AC_MSB  = 6;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_rd_timer.sv
// Loadable down-counter used for every bus phase; tc is high once the loaded
// count has run out and stays high until the next load.
module lcd_rd_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/lcd1602_reader.sv
// HD44780 read-cycle engine: single BF/AC or data reads, and busy-flag polling.
// Define LCD_4BIT_EN for the 4-bit bus (two nibble strobes per byte on lcd_dat_i[7:4]).
module lcd1602_reader
    import lcd1602_pkg::*;
#(
    parameter int T_AS     = 2,
    parameter int T_EH     = 12,
    parameter int T_AH     = 2,
    parameter int T_GAP    = 50,
    parameter int POLL_MAX = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          req_rs,
    input  logic          req_poll,
    output logic          ready,
    output logic [7:0]    rdata,
    output logic          rvalid,
    output logic          busy_flag,
    output logic [6:0]    addr_cnt,
    output logic          poll_timeout,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    input  logic [7:0]    lcd_dat_i,
    output lcd_rd_state_t state
);

    localparam int TW = $clog2(max4(T_AS, T_EH, T_AH, T_GAP) + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    logic          rs_q;
    logic          poll_q;
    logic          again;
    logic [PW-1:0] poll_cnt;
    logic          more_nib;
    logic          t_load;
    logic          t_tc;
    logic [TW-1:0] t_val;
    int            nxt_dur;

`ifdef LCD_4BIT_EN
    logic       nib_hi;
    logic [3:0] hi_q;
    assign more_nib = nib_hi;
`else
    assign more_nib = 1'b0;
`endif

    // Each transition reloads the timer with the length of the phase being entered.
    always_comb begin
        nxt_dur = T_AS;
        case (state)
            ST_SETUP: nxt_dur = T_EH;
            ST_EN_HI: nxt_dur = T_AH;
            ST_HOLD:  nxt_dur = more_nib ? T_AS : T_GAP;
            default:  nxt_dur = T_AS;
        endcase
        t_val  = TW'(nxt_dur - 1);
        t_load = (state == ST_IDLE) ? (req && ready) : t_tc;
    end

    lcd_rd_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .tc       (t_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ready        <= 1'b1;
            lcd_rs       <= 1'b0;
            lcd_rw       <= 1'b0;
            lcd_en       <= 1'b0;
            rdata        <= '0;
            rvalid       <= 1'b0;
            busy_flag    <= 1'b1;
            addr_cnt     <= '0;
            poll_timeout <= 1'b0;
            rs_q         <= RS_INST;
            poll_q       <= 1'b0;
            again        <= 1'b0;
            poll_cnt     <= '0;
`ifdef LCD_4BIT_EN
            nib_hi       <= 1'b1;
            hi_q         <= '0;
`endif
        end else begin
            rvalid       <= 1'b0;
            poll_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req && ready) begin
                        rs_q     <= req_poll ? RS_INST : req_rs;
                        lcd_rs   <= req_poll ? RS_INST : req_rs;
                        poll_q   <= req_poll;
                        poll_cnt <= '0;
                        ready    <= 1'b0;
                        lcd_rw   <= 1'b1;
                        state    <= ST_SETUP;
`ifdef LCD_4BIT_EN
                        nib_hi   <= 1'b1;
`endif
                    end
                end
                ST_SETUP: begin
                    if (t_tc) begin
                        lcd_en <= 1'b1;
                        state  <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    if (t_tc) begin
                        lcd_en <= 1'b0;
                        state  <= ST_HOLD;
`ifdef LCD_4BIT_EN
                        if (nib_hi) hi_q <= lcd_dat_i[7:4];
                        else        rdata <= {hi_q, lcd_dat_i[7:4]};
`else
                        rdata <= lcd_dat_i;
`endif
                    end
                end
                ST_HOLD: begin
                    if (t_tc) begin
                        if (more_nib) begin
                            // Low nibble follows straight after the hold, RS/RW untouched.
                            state  <= ST_SETUP;
`ifdef LCD_4BIT_EN
                            nib_hi <= 1'b0;
`endif
                        end else begin
                            lcd_rw <= 1'b0;
                            lcd_rs <= 1'b0;
                            state  <= ST_GAP;
                            again  <= 1'b0;
                            if (rs_q == RS_INST) begin
                                busy_flag <= rdata[BF_BIT];
                                addr_cnt  <= rdata[AC_MSB:0];
                            end
                            if (!poll_q || !rdata[BF_BIT]) begin
                                rvalid <= 1'b1;
                            end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                                poll_timeout <= 1'b1;
                            end else begin
                                poll_cnt <= poll_cnt + PW'(1);
                                again    <= 1'b1;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (t_tc) begin
                        if (again) begin
                            state  <= ST_SETUP;
                            lcd_rw <= 1'b1;
                            lcd_rs <= RS_INST;
`ifdef LCD_4BIT_EN
                            nib_hi <= 1'b1;
`endif
                        end else begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd1602_reader.sv
// Bench for lcd1602_reader: directed and random read/poll requests, a bus
// responder feeding lcd_dat_i, and a scoreboard fed by a list-based read model.
module tb_lcd1602_reader;
    import lcd1602_pkg::*;

    localparam int T_AS     = 2;
    localparam int T_EH     = 12;
    localparam int T_AH     = 2;
    localparam int T_GAP    = 50;
    localparam int POLL_MAX = 4;
`ifdef LCD_4BIT_EN
    localparam int NPB = 2;
`else
    localparam int NPB = 1;
`endif
    localparam int RD   = NPB * (T_AS + T_EH + T_AH);
    localparam int LAT  = RD + 1;
    localparam int STEP = RD + T_GAP;

    logic          clk;
    logic          rst;
    logic          req;
    logic          req_rs;
    logic          req_poll;
    logic          ready;
    logic [7:0]    rdata;
    logic          rvalid;
    logic          busy_flag;
    logic [6:0]    addr_cnt;
    logic          poll_timeout;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_en;
    logic [7:0]    lcd_dat_i = 8'h00;
    lcd_rd_state_t state_dbg;

    lcd1602_reader #(
        .T_AS(T_AS), .T_EH(T_EH), .T_AH(T_AH), .T_GAP(T_GAP), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_rs       (req_rs),
        .req_poll     (req_poll),
        .ready        (ready),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .busy_flag    (busy_flag),
        .addr_cnt     (addr_cnt),
        .poll_timeout (poll_timeout),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_en       (lcd_en),
        .lcd_dat_i    (lcd_dat_i),
        .state        (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int           total = 0;
    int           bad   = 0;
    logic [16:0]  exp_q[$];      // {timeout, rdata, busy_flag, addr_cnt}
    int           exp_cyc_q[$];
    logic [7:0]   stim_q[$];
    logic [7:0]   bus_q[$];
    logic         m_bf = 1'b1;
    logic [6:0]   m_ac = 7'h00;
    logic         exp_rs = 1'b0;
    int           en_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- LCD bus responder ----------------
`ifdef LCD_4BIT_EN
    logic [7:0] cur_b;
    logic       nib_sel = 1'b0;
    always @(posedge lcd_en or posedge rst) begin
        if (rst) begin
            nib_sel = 1'b0;
        end else begin
            en_pulses++;
            if (!nib_sel) begin
                cur_b = (bus_q.size() > 0) ? bus_q.pop_front() : 8'($urandom);
                lcd_dat_i = {cur_b[7:4], 4'($urandom)};
                nib_sel = 1'b1;
            end else begin
                lcd_dat_i = {cur_b[3:0], 4'($urandom)};
                nib_sel = 1'b0;
            end
        end
    end
`else
    always @(posedge lcd_en) begin
        en_pulses++;
        if (bus_q.size() > 0) lcd_dat_i = bus_q.pop_front();
        else                  lcd_dat_i = 8'($urandom);
    end
`endif

    // ---------------- bus-timing monitor ----------------
    int   en_run = 0;
    int   rw_run = 0;
    logic rs_ok = 1'b1;
    logic prev_en = 1'b0;
    logic prev_rw = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            en_run = 0; rw_run = 0; rs_ok = 1'b1; prev_en = 1'b0; prev_rw = 1'b0;
        end else begin
            if (lcd_en) begin
                en_run++;
            end else if (prev_en) begin
                check("en_width", en_run, T_EH);
                en_run = 0;
            end
            if (lcd_rw) begin
                rw_run++;
                if (lcd_rs !== exp_rs) rs_ok = 1'b0;
            end else if (prev_rw) begin
                check("rw_window", rw_run, RD);
                check("rs_stable", rs_ok, 1'b1);
                rw_run = 0;
                rs_ok  = 1'b1;
            end
            prev_en = lcd_en;
            prev_rw = lcd_rw;
        end
    end

    // ---------------- result monitor ----------------
    always @(negedge clk) begin
        logic [16:0] e;
        int          c;
        if (rvalid && poll_timeout) begin
            check("rvalid_and_timeout", {rvalid, poll_timeout}, 2'b00);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end else if (rvalid || poll_timeout) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {rvalid, poll_timeout}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("timeout_kind", poll_timeout, e[16]);
                if (!e[16]) check("rdata", rdata, e[15:8]);
                check("busy_flag", busy_flag, e[7]);
                check("addr_cnt", addr_cnt, e[6:0]);
                check("result_cycle", cyc, c);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL %s: ready stuck got 0 expected 1", name);
        end
    endtask

    // Consumes stim_q as the bytes the LCD will return, predicts the outcome
    // from the read rules, then issues one request and tracks its timing.
    task automatic run_req(input logic rs, input logic poll, input logic poke);
        int         n, k, en0;
        logic       tmo, rs_eff;
        logic [7:0] b, last;
        rs_eff = poll ? RS_INST : rs;
        n = 0; tmo = 1'b0; last = 8'h00;
        while (stim_q.size() > 0) begin
            b = stim_q.pop_front();
            bus_q.push_back(b);
            n++;
            last = b;
            if (rs_eff == RS_INST) begin
                m_bf = b[7];
                m_ac = b[6:0];
            end
            if (!poll || !b[7]) break;
            if (n == POLL_MAX) begin
                tmo = 1'b1;
                break;
            end
        end
        stim_q.delete();
        wait_ready("ready_before_req");
        en0    = en_pulses;
        exp_rs = rs_eff;
        req = 1'b1; req_rs = rs; req_poll = poll;
        k = cyc;
        exp_q.push_back({tmo, last, m_bf, m_ac});
        exp_cyc_q.push_back(k + LAT + (n - 1) * STEP);
        @(negedge clk);
        req = 1'b0; req_rs = 1'($urandom); req_poll = 1'($urandom);
        check("ready_low", ready, 1'b0);
        if (poke) begin
            while (cyc < k + LAT + 3) @(negedge clk);
            req = 1'b1; req_rs = 1'($urandom); req_poll = 1'($urandom);
            @(negedge clk);
            req = 1'b0;
        end
        wait_ready("ready_return");
        check("ready_cycle", cyc, k + 1 + n * STEP);
        check("en_pulses", en_pulses - en0, n * NPB);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         k, g, mode, nb;
        logic [7:0] b1, b2;
        rst = 1'b1; req = 1'b0; req_rs = 1'b0; req_poll = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_busy_flag", busy_flag, 1'b1);
        check("rst_addr_cnt", addr_cnt, 7'h00);
        check("rst_timeout", poll_timeout, 1'b0);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        check("rst_lcd_en", lcd_en, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        // data read, BF/AC read, poll that clears on the third read, poll timeout
        stim_q.push_back(8'h41);
        run_req(RS_DATA, 1'b0, 1'b0);
        stim_q.push_back(8'h25);
        run_req(RS_INST, 1'b0, 1'b0);
        stim_q.push_back(8'h80); stim_q.push_back(8'h80); stim_q.push_back(8'h07);
        run_req(RS_INST, 1'b1, 1'b0);
        for (int i = 0; i < POLL_MAX; i++) stim_q.push_back(8'hFF);
        run_req(RS_INST, 1'b1, 1'b0);
        stim_q.push_back(8'h13);
        run_req(RS_INST, 1'b1, 1'b0);

        // reset in the middle of the enable pulse
        exp_rs = RS_DATA;
        bus_q.push_back(8'h5A);
        wait_ready("ready_before_abort");
        req = 1'b1; req_rs = RS_DATA; req_poll = 1'b0;
        @(negedge clk);
        req = 1'b0;
        g = 0;
        while (!lcd_en && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("abort_en_seen", lcd_en, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_en_async", lcd_en, 1'b0);
        check("abort_rw_async", lcd_rw, 1'b0);
        check("abort_ready", ready, 1'b1);
        bus_q.delete();
        m_bf = 1'b1;
        m_ac = 7'h00;
        repeat (3) @(negedge clk);
        check("abort_busy_flag", busy_flag, 1'b1);
        check("abort_rvalid", rvalid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // normal read after reset, with a request poked into the gap
        stim_q.push_back(8'h3C);
        run_req(RS_DATA, 1'b0, 1'b1);

        // req held high retriggers as soon as ready rises
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus_q.push_back(b1);
        bus_q.push_back(b2);
        wait_ready("ready_before_b2b");
        exp_rs = RS_DATA;
        req = 1'b1; req_rs = RS_DATA; req_poll = 1'b0;
        k = cyc;
        exp_q.push_back({1'b0, b1, m_bf, m_ac});
        exp_cyc_q.push_back(k + LAT);
        exp_q.push_back({1'b0, b2, m_bf, m_ac});
        exp_cyc_q.push_back(k + STEP + 1 + LAT);
        while (cyc < k + STEP + 1) @(negedge clk);
        check("b2b_ready_rise", ready, 1'b1);
        @(negedge clk);
        req = 1'b0;
        check("b2b_reaccept", ready, 1'b0);
        wait_ready("b2b_ready_return");
        check("b2b_ready_cycle", cyc, k + 2 * (STEP + 1));

        // random mix of reads and polls
        for (int i = 0; i < 10; i++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                stim_q.push_back(8'($urandom));
                run_req(RS_DATA, 1'b0, 1'b0);
            end else if (mode == 1) begin
                stim_q.push_back(8'($urandom));
                run_req(RS_INST, 1'b0, 1'b0);
            end else begin
                nb = $urandom_range(0, POLL_MAX);
                for (int j = 0; j < nb; j++) stim_q.push_back({1'b1, 7'($urandom)});
                stim_q.push_back({1'b0, 7'($urandom)});
                run_req(1'($urandom), 1'b1, 1'b0);
            end
        end

        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
